// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg : mode encodings and select-width helper for the round-robin mux
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : first set bit of a valid vector, scanning from ptr with wrap
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] idx
);

  int k;

  // Scan from the far end so the smallest rotated offset wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (valid[k]) begin
        found = 1'b1;
        idx   = SW'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_n.sv
// ----------------------------------------------------------------------------
// mux_rr_n : N-channel streaming selector, fixed-select or round-robin,
//            valid/ready on every channel, registered output stage
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux_rr_n
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  input  logic           out_ready
);

  localparam int NP = 1 << SW;

  logic [SW-1:0] ptr;
  logic [NP-1:0] valid_ext;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic          found;
  logic [SW-1:0] cand;
  logic          space;
  logic          go;
  logic [W-1:0]  pick_data;

  // Unused select codes (sel >= N) map onto zero-padded valid bits.
  generate
    if (NP > N) begin : g_pad
      assign valid_ext = {{(NP - N){1'b0}}, in_valid};
    end else begin : g_nopad
      assign valid_ext = in_valid;
    end
  endgenerate

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .valid (in_valid),
    .ptr   (ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign space = !out_valid || out_ready;
  assign found = (mode == MODE_RR) ? rr_found : valid_ext[sel];
  assign cand  = (mode == MODE_RR) ? rr_idx : sel;
  assign go    = !rst && en && space && found;

  always_comb begin
    in_ready  = '0;
    pick_data = '0;
    for (int k = 0; k < N; k++) begin
      if (cand == SW'(k)) begin
        in_ready[k] = go;
        pick_data   = in_data[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (go) begin
      out_valid <= 1'b1;
      out_data  <= pick_data;
      out_chan  <= cand;
      if (mode == MODE_RR) begin
        ptr <= (cand == SW'(N - 1)) ? '0 : cand + SW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
